// File: rtl/int_request_controller_if.sv
// Processor-side interrupt bundle: peripheral requests and masks in, INT/NMI/INTD and status out.
// master = interrupt controller, slave = the CPU/peripheral side that drives requests and INA.
interface int_request_controller_if #(
   parameter int ID_W = 2
);
   localparam int NUM_SRC = 2 ** ID_W;

   logic [NUM_SRC-1:0] irq;
   logic [NUM_SRC-1:0] mask;
   logic               nmi_req;
   logic               INA;
   logic               INT;
   logic               NMI;
   logic               INTD;
   logic               busy;
   logic [ID_W-1:0]    ack_id;
   logic               timeout;

   modport master (
      input  irq, mask, nmi_req, INA,
      output INT, NMI, INTD, busy, ack_id, timeout
   );

   modport slave (
      output irq, mask, nmi_req, INA,
      input  INT, NMI, INTD, busy, ack_id, timeout
   );
endinterface

// File: rtl/int_request_controller.sv
// Edge-triggered interrupt controller: fixed-priority masked arbitration, INT/INA handshake, serial vector on INTD.
// Latency: irq edge sampled at k -> INT after k+1; INA sampled at m -> vector MSB on INTD after m, LSB after m+VEC_W-1.
// Backpressure: REQ holds INT until INA (or, with INTC_TIMEOUT_EN, until TIMEOUT cycles pass); new edges stay pending.
module int_request_controller #(
   parameter int               ID_W     = 2,
   parameter int               VEC_W    = 8,
   parameter logic [VEC_W-1:0] VEC_BASE = 'h20,
   parameter int               TIMEOUT  = 255
) (
   input  logic clk,
   input  logic rst,
   int_request_controller_if.master bus
);
   localparam int NUM_SRC = 2 ** ID_W;
   localparam int CNT_W   = (VEC_W > 2) ? $clog2(VEC_W) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      SEND     = 2'd2,
      WAIT_LOW = 2'd3
   } state_t;

   state_t             state, state_d;
   logic [NUM_SRC-1:0] irq_q;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] eligible;
   logic               nmi_q;
   logic               nmi_pls;
   logic               win_vld;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    ack_id, ack_id_d;
   logic [VEC_W-1:0]   vec;
   logic [VEC_W-1:0]   shreg, shreg_d;
   logic [CNT_W-1:0]   bit_cnt, bit_cnt_d;
   logic               int_q, int_d;
   logic               intd_q, intd_d;
   logic               busy_q, busy_d;

`ifdef INTC_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
   logic             timeout_q, timeout_d;
`endif

   assign rise     = bus.irq & ~irq_q;
   assign eligible = pending & ~mask_or_zero();
   assign vec      = VEC_BASE + VEC_W'(ack_id);

   function automatic logic [NUM_SRC-1:0] mask_or_zero();
      return bus.mask;
   endfunction

   // A new edge on a source wins over the clear issued when it is acknowledged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q   <= '0;
         pending <= '0;
         nmi_q   <= 1'b0;
         nmi_pls <= 1'b0;
      end else begin
         irq_q   <= bus.irq;
         pending <= (pending & ~clr) | rise;
         nmi_q   <= bus.nmi_req;
         nmi_pls <= bus.nmi_req & ~nmi_q;
      end
   end

   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         int_q   <= 1'b0;
         intd_q  <= 1'b0;
         busy_q  <= 1'b0;
         ack_id  <= '0;
         shreg   <= '0;
         bit_cnt <= '0;
`ifdef INTC_TIMEOUT_EN
         tmo_cnt   <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         int_q   <= int_d;
         intd_q  <= intd_d;
         busy_q  <= busy_d;
         ack_id  <= ack_id_d;
         shreg   <= shreg_d;
         bit_cnt <= bit_cnt_d;
`ifdef INTC_TIMEOUT_EN
         tmo_cnt   <= tmo_cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      state_d   = state;
      int_d     = int_q;
      intd_d    = intd_q;
      busy_d    = busy_q;
      ack_id_d  = ack_id;
      shreg_d   = shreg;
      bit_cnt_d = bit_cnt;
      clr       = '0;
`ifdef INTC_TIMEOUT_EN
      tmo_cnt_d = (state == REQ) ? tmo_cnt : '0;
      timeout_d = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (win_vld) begin
               ack_id_d = win_id;
               int_d    = 1'b1;
               busy_d   = 1'b1;
               state_d  = REQ;
            end
         end
         REQ: begin
            if (bus.INA) begin
               int_d       = 1'b0;
               clr[ack_id] = 1'b1;
               shreg_d     = vec;
               intd_d      = vec[VEC_W-1];
               bit_cnt_d   = '0;
               state_d     = SEND;
            end
`ifdef INTC_TIMEOUT_EN
            else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
               // Give up on this request but keep it pending for re-arbitration.
               int_d     = 1'b0;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               tmo_cnt_d = tmo_cnt + TMO_W'(1);
            end
`endif
         end
         SEND: begin
            // The register still holds the bit on the wire in its MSB, so the next one is at VEC_W-2.
            if (bit_cnt == CNT_W'(VEC_W - 1)) begin
               intd_d  = 1'b0;
               state_d = WAIT_LOW;
            end else begin
               intd_d    = shreg[VEC_W-2];
               shreg_d   = shreg << 1;
               bit_cnt_d = bit_cnt + CNT_W'(1);
            end
         end
         WAIT_LOW: begin
            if (!bus.INA) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.INT    = int_q;
   assign bus.NMI    = nmi_pls;
   assign bus.INTD   = intd_q;
   assign bus.busy   = busy_q;
   assign bus.ack_id = ack_id;

`ifdef INTC_TIMEOUT_EN
   assign bus.timeout = timeout_q;
`else
   // Watchdog compiled out: TIMEOUT is accepted for compatibility but has no effect.
   if (TIMEOUT < 0) begin : g_timeout_unused
   end
   assign bus.timeout = 1'b0;
`endif
endmodule
